// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start, 8 data bits LSB first, even parity, stop.
// Bit timing comes from clks_per_bit, latched when a start edge is detected.
module uart_rx_deframer (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  logic [9:0] clks_per_bit,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e     state_q, state_d;
  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       prev_q, prev_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] cpb_q, cpb_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       par_bit_q, par_bit_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

  logic [9:0] half;
  logic       bit_end;

  assign half    = cpb_q >> 1;
  assign bit_end = (cnt_q == cpb_q);

  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d   = state_q;
    s1_d      = rx_line;
    s2_d      = s1_q;
    prev_d    = s2_q;
    cnt_d     = cnt_q + 10'd1;
    cpb_d     = cpb_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Requires a 1->0 transition so a line stuck low never re-triggers.
        if (!s2_q && prev_q) begin
          state_d = START;
          cpb_d   = clks_per_bit;
        end
      end
      START: begin
        if (cnt_q == half) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d     = '0;
          par_bit_d = s2_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          data_d  = shift_q;
          perr_d  = par_bit_q != (^shift_q);
          ferr_d  = ~s2_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      prev_q    <= 1'b1;
      cnt_q     <= '0;
      cpb_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      cpb_q     <= cpb_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule
